// File: rtl/spi_seq_ctrl.sv
// -----------------------------------------------------------------------------
// spi_seq_ctrl
//
// Sequences NUM_STEPS SPI transfers through an external SPI master. For each
// step the current index addresses an external table that supplies the
// transfer width and command. Those values are captured when the transfer is
// launched, so they stay stable for the SPI master until the next launch.
// After reset the block waits PWRUP_CYCLES before it permits any transfer.
// Between transfers it inserts GAP_CYCLES idle cycles. Each transfer is
// guarded by a TIMEOUT_CYCLES watchdog.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   trig        one-cycle request to run a sequence
//   abort       level; stops the sequence at the next safe point
//   spi_done    one-cycle end-of-transfer pulse from the SPI master
//   step_width  table width for the current index
//   step_cmd    table command for the current index
//   spi_start   one-cycle transfer launch pulse
//   spi_cmd     registered command for the current transfer
//   spi_width   registered width for the current transfer
//   index       current step number (table address)
//   busy        sequence in progress
//   seq_done    sticky: all steps completed
//   err_timeout sticky: a transfer exceeded the watchdog limit
// -----------------------------------------------------------------------------
module spi_seq_ctrl #(
  parameter int NUM_STEPS      = 8,
  parameter int PWRUP_CYCLES   = 5000,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic       abort,
  input  logic       spi_done,
  input  logic [7:0] step_width,
  input  logic [1:0] step_cmd,
  output logic       spi_start,
  output logic [1:0] spi_cmd,
  output logic [7:0] spi_width,
  output logic [7:0] index,
  output logic       busy,
  output logic       seq_done,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [31:0] PWRUP_LAST   = 32'(PWRUP_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST     = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [7:0]  LAST_IDX     = 8'(NUM_STEPS - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;          // shared by power-up, watchdog and gap timing
  logic        trig_lat_q, trig_lat_d;
  logic [7:0]  index_q, index_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [7:0]  width_q, width_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        seq_done_q, seq_done_d;
  logic        err_q, err_d;
  logic        accept;

  // A pending or fresh request is accepted only if abort is low (abort wins).
  assign accept = (trig | trig_lat_q) & ~abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    trig_lat_d = trig_lat_q;
    index_d    = index_q;
    cmd_d      = cmd_q;
    width_d    = width_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    seq_done_d = seq_done_q;
    err_d      = err_q;

    case (state_q)
      ST_PWRUP: begin
        // A request during power-up is remembered. If one is pending when
        // power-up ends, it is taken straight away, so the first launch
        // follows the end of power-up without an extra idle cycle.
        trig_lat_d = trig_lat_q | trig;
        cnt_d      = cnt_q + 32'd1;
        if (cnt_q == PWRUP_LAST) begin
          cnt_d = 32'd0;
          if (accept) begin
            state_d    = ST_ISSUE;
            index_d    = 8'd0;
            busy_d     = 1'b1;
            seq_done_d = 1'b0;
            err_d      = 1'b0;
            trig_lat_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept) begin
          state_d    = ST_ISSUE;
          index_d    = 8'd0;
          busy_d     = 1'b1;
          seq_done_d = 1'b0;
          err_d      = 1'b0;
          trig_lat_d = 1'b0;
        end
      end

      ST_ISSUE: begin
        // The table is sampled here, while index is stable. The launch pulse
        // and the captured width/cmd appear together in the next cycle, which
        // is also the first cycle of the watchdog window.
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cmd_d   = step_cmd;
          width_d = step_width;
          start_d = 1'b1;
          cnt_d   = 32'd0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (spi_done) begin
          // spi_done wins over a coincident timeout
          cnt_d = 32'd0;
          if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (index_q == LAST_IDX) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            seq_done_d = 1'b1;
          end else begin
            index_d = index_q + 8'd1;
            state_d = (GAP_CYCLES == 0) ? ST_ISSUE : ST_GAP;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d  = 32'd0;
          busy_d = 1'b0;
          // An abort that was already waiting for this transfer ends quietly
          // in IDLE, without raising the error.
          if (abort) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = 32'd0;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: state_d = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PWRUP;
      cnt_q      <= 32'd0;
      trig_lat_q <= 1'b0;
      index_q    <= 8'd0;
      cmd_q      <= 2'd0;
      width_q    <= 8'd8;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_lat_q <= trig_lat_d;
      index_q    <= index_d;
      cmd_q      <= cmd_d;
      width_q    <= width_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
      err_q      <= err_d;
    end
  end

  assign spi_start   = start_q;
  assign spi_cmd     = cmd_q;
  assign spi_width   = width_q;
  assign index       = index_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for spi_seq_ctrl.
// A timeline model predicts every output on every cycle from the sequencing
// rules. It tracks when the next launch is scheduled and when the in-flight
// transfer started. A responder plays the SPI master. Directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_seq_ctrl;

  localparam int N  = 3;
  localparam int PW = 10;
  localparam int GP = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst, trig, abort;
  logic       resp_done, stray_done;
  logic       spi_done;
  logic [7:0] step_width;
  logic [1:0] step_cmd;
  logic       spi_start;
  logic [1:0] spi_cmd;
  logic [7:0] spi_width;
  logic [7:0] index;
  logic       busy, seq_done, err_timeout;

  logic [7:0] wid_tab [4];
  logic [1:0] cmd_tab [4];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  assign spi_done   = resp_done | stray_done;
  assign step_width = wid_tab[index[1:0]];
  assign step_cmd   = cmd_tab[index[1:0]];

  spi_seq_ctrl #(
    .NUM_STEPS(N), .PWRUP_CYCLES(PW), .GAP_CYCLES(GP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort), .spi_done(spi_done),
    .step_width(step_width), .step_cmd(step_cmd),
    .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_width(spi_width),
    .index(index), .busy(busy), .seq_done(seq_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int         m_pwr, m_issue_at, m_fly, mc;
  bit         m_lat, m_busy, m_done, m_err, m_start, m_en;
  logic [7:0] m_idx, m_width;
  logic [1:0] m_cmd;

  task automatic m_accept();
    m_issue_at = mc + 1;
    m_idx      = 8'd0;
    m_busy     = 1'b1;
    m_done     = 1'b0;
    m_err      = 1'b0;
    m_lat      = 1'b0;
  endtask

  initial begin
    m_en = 1'b0; mc = 0;
    forever begin
      @(negedge clk);
      if (m_en) begin
        chk("spi_start", spi_start, m_start);
        chk("spi_cmd", spi_cmd, m_cmd);
        chk("spi_width", spi_width, m_width);
        chk("index", index, m_idx);
        chk("busy", busy, m_busy);
        chk("seq_done", seq_done, m_done);
        chk("err_timeout", err_timeout, m_err);
      end
      m_start = 1'b0;
      if (rst) begin
        m_pwr = PW; m_lat = 0; m_busy = 0; m_done = 0; m_err = 0;
        m_idx = 0; m_cmd = 0; m_width = 8; m_issue_at = -1; m_fly = -1;
        m_en = 1'b1;
      end else if (m_pwr > 0) begin
        if (trig) m_lat = 1'b1;
        m_pwr--;
        if (m_pwr == 0 && m_lat && !abort) m_accept();
      end else if (!m_busy) begin
        if ((trig || m_lat) && !abort) m_accept();
      end else if (m_fly < 0) begin
        // launch scheduled but not yet issued
        if (abort) begin
          m_busy = 1'b0; m_issue_at = -1;
        end else if (mc == m_issue_at) begin
          m_cmd = cmd_tab[m_idx[1:0]];
          m_width = wid_tab[m_idx[1:0]];
          m_fly = mc + 1;
          m_start = 1'b1;
          m_issue_at = -1;
        end
      end else begin
        // transfer in flight since cycle m_fly
        if (spi_done) begin
          m_fly = -1;
          if (abort) m_busy = 1'b0;
          else if (m_idx == N - 1) begin m_busy = 1'b0; m_done = 1'b1; end
          else begin m_idx = m_idx + 8'd1; m_issue_at = mc + GP + 1; end
        end else if (mc - m_fly == TO - 1) begin
          m_fly = -1; m_busy = 1'b0;
          if (!abort) m_err = 1'b1;
        end
      end
      mc++;
    end
  end

  // ---------------- SPI master responder ----------------
  int         dn = 0;
  logic [7:0] withhold = 8'd255;

  initial begin
    resp_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      resp_done = 1'b0;
      if (rst) dn = 0;
      else begin
        if (dn > 0) begin
          dn--;
          if (dn == 0) resp_done = 1'b1;
        end
        if (spi_start && index != withhold) dn = 5;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic pulse_trig();
    trig = 1'b1; step(); trig = 1'b0;
  endtask

  task automatic wait_start(input int bound, output int at);
    int n;
    n = 0;
    do begin step(); n++; end while (!spi_start && n < bound);
    at = spi_start ? cyc : -1;
  endtask

  task automatic count_starts(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (spi_start) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int s0, s1, s2, sa, sb, sc, sd, sf, n, cnt, t0;
    wid_tab = '{8'd8, 8'd16, 8'd24, 8'd32};
    cmd_tab = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; trig = 1'b0; abort = 1'b0; stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; cyc = 0;
    chk("reset_width", spi_width, 8);
    chk("reset_busy", busy, 0);
    chk("reset_index", index, 0);

    // power-up with an early request, then a full three-step run
    repeat (3) step();
    pulse_trig();
    wait_start(30, s0);
    chk("pwrup_first_start_cycle", s0, 11);
    chk("step0_index", index, 0);
    chk("step0_width", spi_width, 8);
    chk("step0_cmd", spi_cmd, 1);
    repeat (3) step();
    pulse_trig();                         // request while busy: ignored
    wait_start(30, s1);
    chk("step1_start_cycle", s1, 22);
    chk("step1_width", spi_width, 16);
    wait_start(30, s2);
    chk("step2_start_cycle", s2, 33);
    chk("step2_width", spi_width, 24);
    chk("step2_index", index, 2);
    n = 0;
    while (!seq_done && n < 30) begin step(); n++; end
    chk("seq_done_cycle", cyc, 39);
    chk("done_busy", busy, 0);
    chk("done_index", index, 2);

    // watchdog on step 1, then recovery
    withhold = 8'd1;
    t0 = cyc;
    pulse_trig();
    wait_start(30, sa);
    chk("restart_latency", sa - t0, 2);
    wait_start(30, sb);
    chk("gap_spacing", sb - sa, 11);
    chk("timeout_step_index", index, 1);
    n = 0;
    while (!err_timeout && n < 40) begin step(); n++; end
    chk("timeout_cycle", cyc - sb, 20);
    chk("timeout_busy", busy, 0);
    repeat (3) step();
    withhold = 8'd255;
    pulse_trig();
    chk("err_cleared", err_timeout, 0);
    chk("err_restart_index", index, 0);
    chk("err_restart_busy", busy, 1);
    n = 0;
    while (!seq_done && n < 60) begin step(); n++; end
    chk("rerun_done", seq_done, 1);

    // abort during the gap after step 0
    pulse_trig();
    wait_start(30, sc);
    repeat (7) step();
    chk("gap_index", index, 1);
    abort = 1'b1; step(); step(); abort = 1'b0;
    count_starts(20, cnt);
    chk("gap_abort_no_start", cnt, 0);
    chk("gap_abort_busy", busy, 0);
    chk("gap_abort_index", index, 1);

    // abort while a transfer is in flight
    pulse_trig();
    wait_start(30, sd);
    step(); step();
    abort = 1'b1;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk("wait_abort_exit_cycle", cyc - sd, 6);
    chk("wait_abort_index", index, 0);
    abort = 1'b0;
    count_starts(15, cnt);
    chk("wait_abort_no_start", cnt, 0);

    // stray spi_done in IDLE
    stray_done = 1'b1; step(); stray_done = 1'b0; step();
    chk("stray_busy", busy, 0);
    chk("stray_seq_done", seq_done, 0);

    // reset in the middle of a transfer
    pulse_trig();
    wait_start(30, sf);
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_start", spi_start, 0);
    chk("midrst_width", spi_width, 8);
    chk("midrst_cmd", spi_cmd, 0);
    chk("midrst_index", index, 0);
    chk("midrst_busy", busy, 0);
    count_starts(15, cnt);
    chk("midrst_no_start", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_seq_ctrl.md
SPI_SEQ_CTRL -- requirements
Module: spi_seq_ctrl

Interface
REQ-001 Parameter NUM_STEPS, default 8: number of SPI transfers per sequence, range 1..255.
REQ-002 Parameter PWRUP_CYCLES, default 5000: clk cycles after reset before any transfer is permitted.
REQ-003 Parameter GAP_CYCLES, default 4: idle clk cycles inserted between consecutive transfers, range 0..255.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles spent waiting for spi_done per transfer.
REQ-005 clk  input  1  single system clock, all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 trig  input  1  one-cycle pulse requesting a sequence run.
REQ-008 abort  input  1  level; stops the current sequence at the next safe point.
REQ-009 spi_done  input  1  one-cycle pulse from the SPI master marking the end of a transfer.
REQ-010 step_width  input  8  transfer bit width for the current index, from an external table.
REQ-011 step_cmd  input  2  SPI command code for the current index, from the same table.
REQ-012 spi_start  output  1  one-cycle pulse launching a transfer.
REQ-013 spi_cmd  output  2  registered command, valid from the spi_start cycle until the next spi_start.
REQ-014 spi_width  output  8  registered width, same validity as spi_cmd.
REQ-015 index  output  8  current step number, used as the table address.
REQ-016 busy  output  1  high from trig acceptance until the sequence ends.
REQ-017 seq_done  output  1  sticky; sequence completed all NUM_STEPS transfers.
REQ-018 err_timeout  output  1  sticky; a transfer exceeded TIMEOUT_CYCLES.

Function
REQ-019 States: PWRUP, IDLE, ISSUE, WAIT, GAP, DONE, ERR.
REQ-020 PWRUP: counter counts 0..PWRUP_CYCLES-1, then goes to IDLE; trig during PWRUP is latched, not lost.
REQ-021 IDLE: a latched or current trig moves to ISSUE with index=0, busy=1, seq_done=0; the trig latch clears on acceptance.
REQ-022 ISSUE: lasts one cycle; registers step_cmd/step_width into spi_cmd/spi_width, pulses spi_start for exactly one cycle, then goes to WAIT.
REQ-023 WAIT: on spi_done, if index==NUM_STEPS-1 go to DONE, else go to GAP (or straight to ISSUE when GAP_CYCLES==0) with index+1.
REQ-024 WAIT: the watchdog clears on entry; if it reaches TIMEOUT_CYCLES without spi_done, go to ERR and set err_timeout=1.
REQ-025 GAP: counts GAP_CYCLES cycles, then goes to ISSUE; spi_start remains 0 throughout.
REQ-026 DONE: seq_done=1, busy=0, index holds NUM_STEPS-1; a new trig restarts from ISSUE with index=0 and clears seq_done.
REQ-027 ERR: busy=0; only rst or trig leaves ERR; trig clears err_timeout and restarts at index 0.
REQ-028 abort in GAP or ISSUE goes to IDLE with busy=0 and no further spi_start.
REQ-029 abort in WAIT waits for spi_done or timeout first, then goes to IDLE.
REQ-030 Priority: abort over trig; spi_done and timeout in the same cycle count as spi_done.
REQ-031 trig while busy=1 is ignored and not latched.
REQ-032 spi_done outside WAIT is ignored.
REQ-033 Minimum spacing between spi_start pulses is GAP_CYCLES+2 cycles after spi_done.

Reset
REQ-034 While rst=1 at a clk edge: state=PWRUP, all counters=0, trig latch=0.
REQ-035 Output reset values: spi_start=0, spi_cmd=0, spi_width=8, index=0, busy=0, seq_done=0, err_timeout=0.
REQ-036 rst asserted mid-sequence takes effect at the next edge, with no spi_start in that cycle, and re-runs PWRUP.

Verification
REQ-037 PWRUP_CYCLES=10, trig at cycle 3 -> first spi_start within 2 cycles after PWRUP ends, index=0.
REQ-038 NUM_STEPS=3, GAP_CYCLES=4, spi_done 5 cycles after each spi_start -> three spi_start pulses, index 0,1,2, spi_width follows the table per step, then seq_done=1 and busy=0.
REQ-039 TIMEOUT_CYCLES=20 with spi_done withheld on step 1 -> err_timeout=1 at cycle 20 of WAIT, busy=0; a later trig clears the error and restarts at index 0.
REQ-040 abort in GAP after step 0 -> no further spi_start, busy=0, index=1.
REQ-041 abort in WAIT -> the in-flight transfer completes on spi_done, then IDLE is entered.
REQ-042 trig while busy -> ignored; a stray spi_done in IDLE -> no state change; rst mid-WAIT -> all outputs at reset values on the next cycle.
